// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter: region and FSM state enums,
// bus widths and the address-to-region decode.
package bus_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {RAM, VDP, STATUS, DSP, PAD, FLASH, UNMAPPED} region_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Bit 19 wins over the region field, so flash covers the whole upper half.
  function automatic region_e region_of(input logic [ADDR_W-1:0] address);
    region_e r;
    if (address[19]) r = FLASH;
    else begin
      case (address[18:16])
        3'd0:    r = RAM;
        3'd1:    r = VDP;
        3'd2:    r = STATUS;
        3'd3:    r = DSP;
        3'd4:    r = PAD;
        default: r = UNMAPPED;
      endcase
    end
    return r;
  endfunction
endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side requests/responses plus the shared bus toward the region decoder.
interface bus_arbiter_if;
  import bus_pkg::*;
  logic              m0_valid, m1_valid;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ready, m1_ready;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              bus_valid;
  logic [ADDR_W-1:0] bus_address;
  logic [STRB_W-1:0] bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              flash_ready;
  logic              grant;
  logic              bus_error;

  modport slave (
    input  m0_valid, m1_valid, m0_address, m1_address, m0_wstrb, m1_wstrb,
           m0_wdata, m1_wdata, bus_rdata, flash_ready,
    output m0_ready, m1_ready, m0_rdata, m1_rdata, bus_valid, bus_address,
           bus_wstrb, bus_wdata, grant, bus_error
  );

  modport master (
    output m0_valid, m1_valid, m0_address, m1_address, m0_wstrb, m1_wstrb,
           m0_wdata, m1_wdata, bus_rdata, flash_ready,
    input  m0_ready, m1_ready, m0_rdata, m1_rdata, bus_valid, bus_address,
           bus_wstrb, bus_wdata, grant, bus_error
  );
endinterface

// File: rtl/bus_arbiter_region_wait.sv
// Combinational address -> (region, initial wait count) lookup.
module bus_region_wait
  import bus_pkg::*;
#(
  parameter int RAM_WAIT      = 0,
  parameter int VDP_WAIT      = 1,
  parameter int STATUS_WAIT   = 0,
  parameter int DSP_WAIT      = 1,
  parameter int PAD_WAIT      = 0,
  parameter int FLASH_TIMEOUT = 255
) (
  input  logic [ADDR_W-1:0] address_i,
  output region_e           region_o,
  output logic [CNT_W-1:0]  wait_o
);
  always_comb begin
    region_o = region_of(address_i);
    wait_o   = '0;
    case (region_o)
      RAM:     wait_o = CNT_W'(RAM_WAIT);
      VDP:     wait_o = CNT_W'(VDP_WAIT);
      STATUS:  wait_o = CNT_W'(STATUS_WAIT);
      DSP:     wait_o = CNT_W'(DSP_WAIT);
      PAD:     wait_o = CNT_W'(PAD_WAIT);
      FLASH:   wait_o = CNT_W'(FLASH_TIMEOUT);
      default: wait_o = '0;
    endcase
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter with per-region wait states and flash
// completion/timeout; IDLE -> ACCESS -> RESP per transaction.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int RAM_WAIT      = 0,
  parameter int VDP_WAIT      = 1,
  parameter int STATUS_WAIT   = 0,
  parameter int DSP_WAIT      = 1,
  parameter int PAD_WAIT      = 0,
  parameter int FLASH_TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset_n,
  bus_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  region_e           region_q, region_d, sel_region;
  logic [CNT_W-1:0]  wait_q, wait_d, sel_wait;
  logic              grant_q, grant_d, last_q, last_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              pick;

  // On a tie the master not served last wins; otherwise whoever is asking.
  assign pick     = (bus.m0_valid && bus.m1_valid) ? ~last_q : bus.m1_valid;
  assign sel_addr = pick ? bus.m1_address : bus.m0_address;

  bus_region_wait #(
    .RAM_WAIT(RAM_WAIT), .VDP_WAIT(VDP_WAIT), .STATUS_WAIT(STATUS_WAIT),
    .DSP_WAIT(DSP_WAIT), .PAD_WAIT(PAD_WAIT), .FLASH_TIMEOUT(FLASH_TIMEOUT)
  ) u_region (
    .address_i(sel_addr),
    .region_o (sel_region),
    .wait_o   (sel_wait)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      region_q <= RAM;
      wait_q   <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      wait_q   <= wait_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    wait_d   = wait_q;
    grant_d  = grant_q;
    last_d   = last_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          grant_d  = pick;
          addr_d   = sel_addr;
          wstrb_d  = pick ? bus.m1_wstrb : bus.m0_wstrb;
          wdata_d  = pick ? bus.m1_wdata : bus.m0_wdata;
          region_d = sel_region;
          wait_d   = sel_wait;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        case (region_q)
          UNMAPPED: begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
          FLASH: begin
            // Completion takes priority over a timeout landing in the same cycle.
            if (bus.flash_ready) begin
              rdata_d = bus.bus_rdata;
              state_d = RESP;
            end else if (wait_q == '0) begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = RESP;
            end else begin
              wait_d = wait_q - 1'b1;
            end
          end
          default: begin
            if (wait_q != '0) begin
              wait_d = wait_q - 1'b1;
            end else begin
              rdata_d = bus.bus_rdata;
              state_d = RESP;
            end
          end
        endcase
      end
      RESP: begin
        last_d  = grant_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bus_valid   = (state_q == ACCESS) && (region_q != UNMAPPED);
  assign bus.bus_address = addr_q;
  assign bus.bus_wstrb   = wstrb_q;
  assign bus.bus_wdata   = wdata_q;
  assign bus.m0_ready    = (state_q == RESP) && !grant_q;
  assign bus.m1_ready    = (state_q == RESP) && grant_q;
  assign bus.m0_rdata    = rdata_q;
  assign bus.m1_rdata    = rdata_q;
  assign bus.bus_error   = (state_q == RESP) && err_q;
  assign bus.grant       = grant_q;
endmodule
